// File: rtl/spi_receiver.sv
// SPI-slave SUMP command receiver: shifts MOSI bytes in and assembles short or long commands.
// It also decodes the query opcodes for the neighbouring spi_transmitter.
module spi_receiver #(
    parameter int unsigned TIMEOUT_CYCLES  = 100000,
    parameter logic [7:0]  OPC_QUERY_ID    = 8'h02,
    parameter logic [7:0]  OPC_QUERY_INPUT = 8'h06
) (
    input  logic        clock,
    input  logic        extReset_n,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic [7:0]  opcode,
    output logic [31:0] data,
    output logic        execute,
    output logic        query_id,
    output logic        query_dataIn,
    output logic        rx_error
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARGS = 2'd1,
        EXEC = 2'd2
    } state_t;

    logic              dly_sclk;
    logic [BYTE_W-1:0] shreg;
    logic [BIT_W-1:0]  bitcnt;
    logic              rise;
    logic              rx_v;
    logic [BYTE_W-1:0] rx_b;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [CNT_W-1:0]  tcnt, tcnt_n;
    logic              pend_v, pend_v_n;
    logic [BYTE_W-1:0] pend_b, pend_b_n;
    logic [BYTE_W-1:0] opcode_n;
    logic [DATA_W-1:0] data_n;
    logic              execute_n, query_id_n, query_dataIn_n, rx_error_n;
    logic              in_v;
    logic [BYTE_W-1:0] in_b;

    assign rise = sclk & ~dly_sclk & ~cs;
    assign rx_v = rise && (bitcnt == BIT_W'(7));
    assign rx_b = {shreg[BYTE_W-2:0], mosi};

    // Bit shifter; deasserted CS drops any partial byte but leaves FSM context intact
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            dly_sclk <= 1'b0;
            shreg    <= '0;
            bitcnt   <= '0;
        end else begin
            dly_sclk <= sclk;
            if (cs) begin
                bitcnt <= '0;
            end else if (rise) begin
                shreg  <= rx_b;
                bitcnt <= bitcnt + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state        <= IDLE;
            idx          <= '0;
            tcnt         <= '0;
            pend_v       <= 1'b0;
            pend_b       <= '0;
            opcode       <= '0;
            data         <= '0;
            execute      <= 1'b0;
            query_id     <= 1'b0;
            query_dataIn <= 1'b0;
            rx_error     <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            tcnt         <= tcnt_n;
            pend_v       <= pend_v_n;
            pend_b       <= pend_b_n;
            opcode       <= opcode_n;
            data         <= data_n;
            execute      <= execute_n;
            query_id     <= query_id_n;
            query_dataIn <= query_dataIn_n;
            rx_error     <= rx_error_n;
        end
    end

    // A byte held over from the EXEC cycle is consumed before any newly arrived byte
    always_comb begin
        state_n        = state;
        idx_n          = idx;
        tcnt_n         = tcnt;
        pend_v_n       = 1'b0;
        pend_b_n       = pend_b;
        opcode_n       = opcode;
        data_n         = data;
        execute_n      = 1'b0;
        query_id_n     = 1'b0;
        query_dataIn_n = 1'b0;
        rx_error_n     = 1'b0;
        in_v           = pend_v | rx_v;
        in_b           = pend_v ? pend_b : rx_b;

        case (state)
            IDLE: begin
                if (pend_v && rx_v) begin
                    pend_v_n = 1'b1;
                    pend_b_n = rx_b;
                end
                if (in_v) begin
                    opcode_n = in_b;
                    if (in_b[BYTE_W-1]) begin
                        state_n = ARGS;
                        idx_n   = '0;
                        tcnt_n  = '0;
                    end else begin
                        state_n = EXEC;
                    end
                end
            end
            ARGS: begin
                if (pend_v && rx_v) begin
                    pend_v_n = 1'b1;
                    pend_b_n = rx_b;
                end
                if (in_v) begin
                    data_n[{idx, 3'b000} +: BYTE_W] = in_b;
                    tcnt_n = '0;
                    if (idx == IDX_W'(3)) begin
                        state_n = EXEC;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else if (tcnt == TMO_LAST) begin
                    state_n    = IDLE;
                    rx_error_n = 1'b1;
                end else begin
                    tcnt_n = tcnt + CNT_W'(1);
                end
            end
            EXEC: begin
                execute_n      = 1'b1;
                query_id_n     = (opcode == OPC_QUERY_ID);
                query_dataIn_n = (opcode == OPC_QUERY_INPUT);
                state_n        = IDLE;
                if (rx_v) begin
                    pend_v_n = 1'b1;
                    pend_b_n = rx_b;
                end else begin
                    pend_v_n = pend_v;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
